// File: rtl/tone_period_decoder.sv
// rtl/tone_period_decoder.sv - GPIO tone period measurement, note classification and lock; optional input filter under TONE_DEGLITCH_EN
module tone_period_decoder #(
  parameter int CLK_HZ     = 50000000,
  parameter int TOL_SHIFT  = 6,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 262143,
  parameter int CNT_W      = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [1:0]       note,
  output logic             note_valid,
  output logic             timeout
);

  localparam int LOCK_W = $clog2(LOCK_COUNT + 1);
  localparam logic [LOCK_W-1:0] LOCK_FULL = LOCK_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  // Nominal note periods in clk cycles and their acceptance windows
  localparam int PER_G = CLK_HZ / 392;
  localparam int PER_A = CLK_HZ / 440;
  localparam int PER_B = CLK_HZ / 494;
  localparam int PER_C = CLK_HZ / 523;
  localparam logic [CNT_W-1:0] LO_G = CNT_W'(PER_G - (PER_G >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] HI_G = CNT_W'(PER_G + (PER_G >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] LO_A = CNT_W'(PER_A - (PER_A >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] HI_A = CNT_W'(PER_A + (PER_A >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] LO_B = CNT_W'(PER_B - (PER_B >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] HI_B = CNT_W'(PER_B + (PER_B >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] LO_C = CNT_W'(PER_C - (PER_C >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] HI_C = CNT_W'(PER_C + (PER_C >> TOL_SHIFT));

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } stateT;

  stateT             state;
  stateT             stateNext;
  logic              sync1;
  logic              sync2;
  logic              level;
  logic              levelPrev;
  logic              edgeDet;
  logic [CNT_W-1:0]  cnt;
  logic [LOCK_W-1:0] lockCnt;
  logic              matchHit;
  logic [1:0]        matchNote;
  logic [CNT_W-1:0]  periodNext;
  logic              periodValidNext;
  logic [1:0]        noteNext;
  logic [LOCK_W-1:0] lockNext;
  logic              timeoutNext;

  // Two-flop synchronizer for the asynchronous GPIO input
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
    end
  end

`ifdef TONE_DEGLITCH_EN
  logic [1:0] stableHist;

  // Filtered level moves only after three agreeing synchronized samples
  always_ff @(posedge clk) begin
    if (!reset) begin
      stableHist <= 2'b00;
      level      <= 1'b0;
    end else begin
      stableHist <= {stableHist[0], sync2};
      if (sync2 && (&stableHist)) begin
        level <= 1'b1;
      end else if (!sync2 && !(|stableHist)) begin
        level <= 1'b0;
      end
    end
  end
`else
  assign level = sync2;
`endif

  // Registered rising-edge detect on the (optionally filtered) level
  always_ff @(posedge clk) begin
    if (!reset) begin
      levelPrev <= 1'b0;
      edgeDet   <= 1'b0;
    end else begin
      levelPrev <= level;
      edgeDet   <= level & ~levelPrev;
    end
  end

  // Period counter: restarts at 1 on each edge, saturates instead of wrapping
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (edgeDet) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Classify the counter value, which equals the measured period on an edge cycle
  always_comb begin
    matchHit  = 1'b1;
    matchNote = 2'd0;
    if (cnt >= LO_G && cnt <= HI_G) begin
      matchNote = 2'd0;
    end else if (cnt >= LO_A && cnt <= HI_A) begin
      matchNote = 2'd1;
    end else if (cnt >= LO_B && cnt <= HI_B) begin
      matchNote = 2'd2;
    end else if (cnt >= LO_C && cnt <= HI_C) begin
      matchNote = 2'd3;
    end else begin
      matchHit = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= WAIT_FIRST;
    end else begin
      state <= stateNext;
    end
  end

  // Next state: the first edge arms measurement, a silent input drops back
  always_comb begin
    stateNext = state;
    case (state)
      WAIT_FIRST: if (edgeDet) stateNext = MEASURE;
      MEASURE:    if (!edgeDet && cnt >= TIMEOUT_CNT) stateNext = WAIT_FIRST;
      default:    stateNext = WAIT_FIRST;
    endcase
  end

  // Output decisions; an edge takes priority over a simultaneous timeout
  always_comb begin
    periodNext      = period;
    periodValidNext = 1'b0;
    noteNext        = note;
    lockNext        = lockCnt;
    timeoutNext     = timeout;
    case (state)
      WAIT_FIRST: begin
        if (edgeDet) timeoutNext = 1'b0;
      end
      MEASURE: begin
        if (edgeDet) begin
          periodNext      = cnt;
          periodValidNext = 1'b1;
          if (!matchHit) begin
            lockNext = '0;
          end else if (matchNote == note) begin
            if (lockCnt != LOCK_FULL) lockNext = lockCnt + 1'b1;
          end else begin
            noteNext = matchNote;
            lockNext = LOCK_W'(1);
          end
        end else if (cnt >= TIMEOUT_CNT) begin
          timeoutNext = 1'b1;
          lockNext    = '0;
        end
      end
      default: begin
        lockNext = '0;
      end
    endcase
  end

  // Output and lock registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      period       <= '0;
      period_valid <= 1'b0;
      note         <= 2'd0;
      lockCnt      <= '0;
      timeout      <= 1'b0;
    end else begin
      period       <= periodNext;
      period_valid <= periodValidNext;
      note         <= noteNext;
      lockCnt      <= lockNext;
      timeout      <= timeoutNext;
    end
  end

  assign note_valid = (lockCnt == LOCK_FULL);

endmodule
